// File: rtl/fsm_door_timed.sv
// Door controller with motor supervision: opening/closing via end switches, auto-close
// hold timer, obstacle reversal, motor run-time watchdog and a latched, blinking fault state.
module fsm_door_timed #(
    parameter int OPEN_HOLD_CYC     = 20_000_000,
    parameter int MOTOR_TIMEOUT_CYC = 16_000_000,
    parameter int BLINK_CYC         = 1_000_000
) (
    input  logic clk2m,
    input  logic rst,
    input  logic key_up,
    input  logic key_down,
    input  logic sense_up,
    input  logic sense_down,
    input  logic obstacle,
    input  logic fault_clr,
    output logic ml,
    output logic mr,
    output logic light_red,
    output logic light_green,
    output logic fault
);

    localparam int MAX_AB  = (OPEN_HOLD_CYC > MOTOR_TIMEOUT_CYC) ? OPEN_HOLD_CYC : MOTOR_TIMEOUT_CYC;
    localparam int MAX_CYC = (MAX_AB > BLINK_CYC) ? MAX_AB : BLINK_CYC;
    localparam int TW      = $clog2(MAX_CYC) + 1;

    localparam logic [TW-1:0] TIMER_MAX  = '1;
    localparam logic [TW-1:0] HOLD_LAST  = TW'(OPEN_HOLD_CYC - 1);
    localparam logic [TW-1:0] MOTOR_LAST = TW'(MOTOR_TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] BLINK_LAST = TW'(BLINK_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_OPENING = 3'd1,
        S_OPEN    = 3'd2,
        S_CLOSING = 3'd3,
        S_CLOSED  = 3'd4,
        S_FAULT   = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          blink_q, blink_d;
    logic          timer_clr;

    always_ff @(posedge clk2m or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            blink_q <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            blink_q <= blink_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        blink_d   = blink_q;
        timer_clr = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (key_up)        state_d = S_OPENING;
                else if (key_down) state_d = S_CLOSING;
            end
            S_OPENING: begin
                if (sense_up)                 state_d = S_OPEN;
                else if (timer_q == MOTOR_LAST) state_d = S_FAULT;
            end
            S_OPEN: begin
                if (key_up)                    timer_clr = 1'b1;
                else if (key_down)             state_d = S_CLOSING;
                else if (timer_q == HOLD_LAST) state_d = S_CLOSING;
            end
            S_CLOSING: begin
                // Reversal beats the end switch so a late obstacle never gets crushed.
                if (obstacle || key_up)         state_d = S_OPENING;
                else if (sense_down)            state_d = S_CLOSED;
                else if (timer_q == MOTOR_LAST) state_d = S_FAULT;
            end
            S_CLOSED: begin
                if (key_up && !key_down) state_d = S_OPENING;
            end
            S_FAULT: begin
                if (fault_clr) begin
                    state_d = S_IDLE;
                end else if (timer_q == BLINK_LAST) begin
                    blink_d   = ~blink_q;
                    timer_clr = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Both end switches closed at once means a broken sensor: overrides everything.
        if (state_q != S_FAULT && sense_up && sense_down) state_d = S_FAULT;

        if (state_d == S_FAULT && state_q != S_FAULT) blink_d = 1'b1;

        if (state_d != state_q || timer_clr) timer_d = '0;
        else if (timer_q != TIMER_MAX)       timer_d = timer_q + 1'b1;
        else                                 timer_d = timer_q;
    end

    always_comb begin
        ml          = 1'b0;
        mr          = 1'b0;
        light_red   = 1'b1;
        light_green = 1'b0;
        fault       = 1'b0;
        case (state_q)
            S_OPENING: mr = 1'b1;
            S_CLOSING: ml = 1'b1;
            S_OPEN: begin
                light_red   = 1'b0;
                light_green = 1'b1;
            end
            S_FAULT: begin
                fault     = 1'b1;
                light_red = blink_q;
            end
            default: ;
        endcase
    end

endmodule
